// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
//   DIV_N      : default divisor/remainder width (dividend/quotient are 2*DIV_N)
//   DIV_CNT_W  : iteration counter width for the default size
//   div_state_e: controller states
package div_pkg;

  localparam int unsigned DIV_N     = 4;
  localparam int unsigned DIV_CNT_W = $clog2(2 * DIV_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   pr        : current partial remainder (N+1 bits)
//   dvd_bit   : next dividend bit shifted into the remainder
//   dvs       : divisor
//   pr_next_c : updated partial remainder
//   q_bit_c   : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic [N:0]   pr,
  input  logic         dvd_bit,
  input  logic [N-1:0] dvs,
  output logic [N:0]   pr_next_c,
  output logic         q_bit_c
);

  // Shift is taken one bit wider than the remainder so the compare is exact
  // for any pr; the difference always fits back into N+1 bits.
  logic [N+1:0] pr_shift;
  logic [N+1:0] dvs_ext;

  always_comb begin
    pr_shift  = {pr, dvd_bit};
    dvs_ext   = (N+2)'(dvs);
    q_bit_c   = 1'b0;
    pr_next_c = (N+1)'(pr_shift);
    if (pr_shift >= dvs_ext) begin
      q_bit_c   = 1'b1;
      pr_next_c = (N+1)'(pr_shift - dvs_ext);
    end
  end

endmodule

// File: rtl/div_sequential.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : level request, sampled only in IDLE
//   a     : 2N-bit dividend
//   b     : N-bit divisor
//   q     : 2N-bit quotient (registered, held between operations)
//   r     : N-bit remainder (registered, held between operations)
//   busy  : high while iterating
//   done  : one-cycle pulse when q/r/dbz update
//   dbz   : divide-by-zero flag, updated with q/r
module div_sequential
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic           dbz
);

  localparam int unsigned W     = 2 * N;
  localparam int unsigned CNT_W = $clog2(2 * N);

  div_state_e       state, state_d;
  logic [W-1:0]     dvd, dvd_d;   // dividend shifts out the top, quotient bits fill the bottom
  logic [N-1:0]     dvs, dvs_d;
  logic [N:0]       pr, pr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [W-1:0]     q_d;
  logic [N-1:0]     r_d;
  logic             busy_d, done_d, dbz_d;

  logic [N:0]       pr_next_c;
  logic             q_bit_c;

  div_step #(.N(N)) u_step (
    .pr        (pr),
    .dvd_bit   (dvd[W-1]),
    .dvs       (dvs),
    .pr_next_c (pr_next_c),
    .q_bit_c   (q_bit_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    dvd_d   = dvd;
    dvs_d   = dvs;
    pr_d    = pr;
    cnt_d   = cnt;
    q_d     = q;
    r_d     = r;
    busy_d  = busy;
    done_d  = 1'b0;
    dbz_d   = dbz;

    case (state)
      IDLE: begin
        if (start) begin
          if (b != '0) begin
            dvd_d   = a;
            dvs_d   = b;
            pr_d    = '0;
            cnt_d   = CNT_W'(W - 1);
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            q_d     = '1;
            r_d     = '0;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      CALC: begin
        dvd_d = {dvd[W-2:0], q_bit_c};
        pr_d  = pr_next_c;
        cnt_d = cnt - CNT_W'(1);
        if (cnt == '0) begin
          q_d     = {dvd[W-2:0], q_bit_c};
          r_d     = pr_next_c[N-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      pr    <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= state_d;
      dvd   <= dvd_d;
      dvs   <= dvs_d;
      pr    <= pr_d;
      cnt   <= cnt_d;
      q     <= q_d;
      r     <= r_d;
      busy  <= busy_d;
      done  <= done_d;
      dbz   <= dbz_d;
    end
  end

endmodule

// File: doc/div_sequential.md
Name: div_sequential

Overview:
- Sequential restoring divider. It is the inverse companion of the team's pipelined multiplier: given a product-width dividend and an operand-width divisor, it returns the quotient and remainder.
- It lives in the same arithmetic block set and uses the same clk/rst_n/start conventions, so the multiplier bench style can drive it.
- It produces one quotient bit per cycle. Results are registered and held until the next operation completes.

Parameters:
- N, 4, divisor/remainder width; dividend and quotient width is 2N.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  level request; sampled only in IDLE.
- a  input  2N  dividend.
- b  input  N  divisor.
- q  output  2N  quotient, registered.
- r  output  N  remainder, registered.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when q/r/dbz update.
- dbz  output  1  divide-by-zero flag, registered with q/r.

Behaviour:
- Reset: one clock is used; reset is synchronous and active-low. With rst_n=0 at a rising edge: state=IDLE; q=0, r=0, busy=0, done=0, dbz=0; internal registers cleared. This applies in any state, including mid-CALC; no partial result is ever written to q/r.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1, b!=0:
  - Latch a into the dividend shift register and b into the divisor register.
  - Clear the partial remainder (N+1 bits) and set the counter to 2N-1.
  - Next state CALC; busy=1 from the next cycle.
- IDLE, start=1, b==0:
  - Next state DONE. At that edge q={2N{1}}, r=0, dbz=1, done=1.
- IDLE, start=0: remain in IDLE; outputs hold.
- CALC, per cycle:
  - pr' = {pr[N-1:0], msb of dividend}; shift the dividend left.
  - If pr' >= {1'b0, divisor}: pr = pr' - divisor and shift in quotient bit 1.
  - Otherwise pr = pr' and shift in 0.
  - Decrement the counter. On the counter==0 cycle, the next state is DONE.
- Entering DONE from CALC: q=quotient register, r=pr[N-1:0], dbz=0, done=1, busy=0 at the same edge.
- DONE: one cycle only. The next edge returns to IDLE unconditionally, done=0, and start is ignored. q/r/dbz hold.
- Latency: with start sampled at edge k, done is high after edge k+2N and low after edge k+2N+1; for N=4 that is 8 cycles.
  - With start held high continuously, a new operation launches every 2N+2 cycles.
  - q/r stay stable between done pulses, so results are valid 16 cycles after start for N=4.
- start, a and b are ignored during CALC and DONE. Operand changes mid-operation do not affect the result.
- Arithmetic is unsigned throughout. The quotient is full 2N width, so no overflow is possible.
  - Invariant: a == q*b + r, and r < b, whenever dbz=0.

Decomposition:
- Package div_pkg: state enumeration (IDLE, CALC, DONE), default N, localparam for counter width $clog2(2N).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder (N+1 bits), next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once inside div_sequential.

Test Plan:
- a=225, b=15, start pulse -> done after 8 cycles; q=15, r=0, dbz=0, busy high for exactly 8 cycles.
- a=100, b=7 -> q=14, r=2. a=255, b=1 -> q=255, r=0, which confirms a quotient wider than N.
- a=5, b=0 -> done 1 cycle after start; q=8'hFF, r=0, dbz=1. A following a=9, b=3 operation clears dbz and gives q=3, r=0.
- Start a=200, b=9 (q=22, r=2); change a=17, b=4 two cycles into CALC -> result still q=22, r=2; the new operands are used only on the next IDLE launch.
- Assert rst_n=0 for one edge mid-CALC -> q, r, busy, done, dbz all 0 the next cycle, state IDLE; a subsequent start computes correctly.
- Exhaustive sweep: a=0..255, b=0..15 with start held high, checking after 16 cycles (multiplier-bench style) -> a==q*b+r and r<b for all b!=0; dbz=1 for b=0.
